// File: rtl/id_ex_if.sv
// id_ex_if: ID->EX handshake, forwarding buses and EX outputs
interface id_ex_if #(
    parameter int ALUCTL_W = 15,
    parameter int DATA_W   = 32
);
    logic                flush;
    logic                id_valid;
    logic                id_allowin;
    logic [31:0]         id_pc;
    logic [ALUCTL_W-1:0] id_alu_control;
    logic [4:0]          id_rs_addr;
    logic [4:0]          id_rt_addr;
    logic [DATA_W-1:0]   id_rs_val;
    logic [DATA_W-1:0]   id_rt_val;
    logic [DATA_W-1:0]   id_imm;
    logic [4:0]          id_sa;
    logic                id_a_sel;
    logic                id_b_sel;
    logic                id_wr_en;
    logic [4:0]          id_wr_addr;
    logic                mem_fwd_en;
    logic [4:0]          mem_fwd_addr;
    logic                mem_fwd_rdy;
    logic [DATA_W-1:0]   mem_fwd_data;
    logic                wb_fwd_en;
    logic [4:0]          wb_fwd_addr;
    logic [DATA_W-1:0]   wb_fwd_data;
    logic                mem_allowin;
    logic                ex_to_mem_valid;
    logic [ALUCTL_W-1:0] alu_control;
    logic [DATA_W-1:0]   alu_da;
    logic [DATA_W-1:0]   alu_db;
    logic [31:0]         ex_pc;
    logic [DATA_W-1:0]   ex_store_data;
    logic                ex_wr_en;
    logic [4:0]          ex_wr_addr;

    modport master (
        output flush, id_valid, id_pc, id_alu_control, id_rs_addr, id_rt_addr, id_rs_val, id_rt_val,
               id_imm, id_sa, id_a_sel, id_b_sel, id_wr_en, id_wr_addr, mem_fwd_en, mem_fwd_addr,
               mem_fwd_rdy, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data, mem_allowin,
        input  id_allowin, ex_to_mem_valid, alu_control, alu_da, alu_db, ex_pc, ex_store_data,
               ex_wr_en, ex_wr_addr
    );

    modport slave (
        input  flush, id_valid, id_pc, id_alu_control, id_rs_addr, id_rt_addr, id_rs_val, id_rt_val,
               id_imm, id_sa, id_a_sel, id_b_sel, id_wr_en, id_wr_addr, mem_fwd_en, mem_fwd_addr,
               mem_fwd_rdy, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data, mem_allowin,
        output id_allowin, ex_to_mem_valid, alu_control, alu_da, alu_db, ex_pc, ex_store_data,
               ex_wr_en, ex_wr_addr
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with MEM/WB operand forwarding and load-use stall
module id_ex_stage #(
    parameter int ALUCTL_W = 15,
    parameter int DATA_W   = 32
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic [31:0]         pc;
        logic [ALUCTL_W-1:0] op;
        logic [4:0]          rs_addr;
        logic [4:0]          rt_addr;
        logic [DATA_W-1:0]   rs_val;
        logic [DATA_W-1:0]   rt_val;
        logic [DATA_W-1:0]   imm;
        logic [4:0]          sa;
        logic                a_sel;
        logic                b_sel;
        logic                wr_en;
        logic [4:0]          wr_addr;
    } fields_t;

    fields_t           f_q, f_d;
    logic              ex_valid_q, ex_valid_d;
    logic              rs_mem_hit, rt_mem_hit, rs_wb_hit, rt_wb_hit;
    logic              ex_ready_go, allowin;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    // r0 never hits a bypass, so its operand is always zero
    assign rs_mem_hit = bus.mem_fwd_en && f_q.rs_addr != 5'd0 && bus.mem_fwd_addr == f_q.rs_addr;
    assign rt_mem_hit = bus.mem_fwd_en && f_q.rt_addr != 5'd0 && bus.mem_fwd_addr == f_q.rt_addr;
    assign rs_wb_hit  = bus.wb_fwd_en  && f_q.rs_addr != 5'd0 && bus.wb_fwd_addr  == f_q.rs_addr;
    assign rt_wb_hit  = bus.wb_fwd_en  && f_q.rt_addr != 5'd0 && bus.wb_fwd_addr  == f_q.rt_addr;
    assign fwd_rs = f_q.rs_addr == 5'd0 ? '0 : rs_mem_hit ? bus.mem_fwd_data : rs_wb_hit ? bus.wb_fwd_data : f_q.rs_val;
    assign fwd_rt = f_q.rt_addr == 5'd0 ? '0 : rt_mem_hit ? bus.mem_fwd_data : rt_wb_hit ? bus.wb_fwd_data : f_q.rt_val;
    // rt is always needed because it also feeds the store data path
    assign ex_ready_go = bus.mem_fwd_rdy || !((rs_mem_hit && !f_q.a_sel) || rt_mem_hit);
    assign allowin     = !ex_valid_q || (ex_ready_go && bus.mem_allowin);

    assign bus.id_allowin      = allowin;
    assign bus.ex_to_mem_valid = ex_valid_q && ex_ready_go && !bus.flush;
    assign bus.alu_control     = ex_valid_q ? f_q.op : '0;
    assign bus.alu_da          = f_q.a_sel ? {{(DATA_W-5){1'b0}}, f_q.sa} : fwd_rs;
    assign bus.alu_db          = f_q.b_sel ? f_q.imm : fwd_rt;
    assign bus.ex_pc           = f_q.pc;
    assign bus.ex_store_data   = fwd_rt;
    assign bus.ex_wr_en        = ex_valid_q && f_q.wr_en;
    assign bus.ex_wr_addr      = f_q.wr_addr;

    // next state: flush drops everything, accept loads from ID, a stall refreshes operands from the bypass
    always_comb begin
        f_d        = f_q;
        ex_valid_d = ex_valid_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (allowin) begin
            ex_valid_d = bus.id_valid;
            if (bus.id_valid)
                f_d = '{pc: bus.id_pc, op: bus.id_alu_control, rs_addr: bus.id_rs_addr,
                        rt_addr: bus.id_rt_addr, rs_val: bus.id_rs_val, rt_val: bus.id_rt_val,
                        imm: bus.id_imm, sa: bus.id_sa, a_sel: bus.id_a_sel, b_sel: bus.id_b_sel,
                        wr_en: bus.id_wr_en, wr_addr: bus.id_wr_addr};
        end else begin
            f_d.rs_val = fwd_rs;
            f_d.rt_val = fwd_rt;
        end
    end

    // pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            f_q        <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            f_q        <= f_d;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for the ID->EX stage
module tb_id_ex_stage;
    localparam logic [14:0] ADDU = 15'h0001;
    localparam logic [14:0] SUBU = 15'h0002;
    localparam logic [14:0] SLL  = 15'h0100;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] da;
        logic [31:0] db;
        logic [14:0] ctl;
        logic        wen;
        logic [4:0]  wa;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    id_ex_if ifc ();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        ifc.flush = 0; ifc.id_valid = 0; ifc.id_pc = 0; ifc.id_alu_control = 0;
        ifc.id_rs_addr = 0; ifc.id_rt_addr = 0; ifc.id_rs_val = 0; ifc.id_rt_val = 0;
        ifc.id_imm = 0; ifc.id_sa = 0; ifc.id_a_sel = 0; ifc.id_b_sel = 0;
        ifc.id_wr_en = 0; ifc.id_wr_addr = 0;
        ifc.mem_fwd_en = 0; ifc.mem_fwd_addr = 0; ifc.mem_fwd_rdy = 1; ifc.mem_fwd_data = 0;
        ifc.wb_fwd_en = 0; ifc.wb_fwd_addr = 0; ifc.wb_fwd_data = 0; ifc.mem_allowin = 1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [14:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic [31:0] imm, input logic [4:0] sa, input logic asel,
                         input logic bsel, input logic wen, input logic [4:0] wa);
        ifc.id_valid = 1; ifc.id_pc = pc; ifc.id_alu_control = op;
        ifc.id_rs_addr = rs; ifc.id_rt_addr = rt; ifc.id_rs_val = rsv; ifc.id_rt_val = rtv;
        ifc.id_imm = imm; ifc.id_sa = sa; ifc.id_a_sel = asel; ifc.id_b_sel = bsel;
        ifc.id_wr_en = wen; ifc.id_wr_addr = wa;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] da, input logic [31:0] db,
                        input logic [14:0] ctl, input logic wen, input logic [4:0] wa);
        exp_t e;
        e.pc = pc; e.da = da; e.db = db; e.ctl = ctl; e.wen = wen; e.wa = wa;
        sb.push_back(e);
    endtask

    task automatic retire(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(ifc.ex_to_mem_valid), 32'd1);
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s_sb got=empty exp=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_pc"}, ifc.ex_pc, e.pc);
            chk({tag, "_da"}, ifc.alu_da, e.da);
            chk({tag, "_db"}, ifc.alu_db, e.db);
            chk({tag, "_ctl"}, 32'(ifc.alu_control), 32'(e.ctl));
            chk({tag, "_wen"}, 32'(ifc.ex_wr_en), 32'(e.wen));
            chk({tag, "_wa"}, 32'(ifc.ex_wr_addr), 32'(e.wa));
        end
    endtask

    initial begin
        clr();
        cyc(); cyc();
        smp();
        chk("rst_ctl", 32'(ifc.alu_control), 32'd0);
        chk("rst_vld", 32'(ifc.ex_to_mem_valid), 32'd0);
        chk("rst_allowin", 32'(ifc.id_allowin), 32'd1);
        chk("rst_da", ifc.alu_da, 32'd0);
        chk("rst_db", ifc.alu_db, 32'd0);
        chk("rst_wen", 32'(ifc.ex_wr_en), 32'd0);
        cyc();
        rst = 0;
        // back-to-back RAW through MEM
        issue(32'h100, ADDU, 5'd1, 5'd2, 32'h5, 32'h7, 0, 0, 0, 0, 1, 5'd3);
        push(32'h100, 32'h5, 32'h7, ADDU, 1, 5'd3);
        cyc();
        issue(32'h104, SUBU, 5'd3, 5'd1, 32'h0, 32'h5, 0, 0, 0, 0, 1, 5'd4);
        push(32'h104, 32'h10, 32'h5, SUBU, 1, 5'd4);
        smp();
        retire("addu");
        cyc();
        ifc.id_valid = 0;
        ifc.mem_fwd_en = 1; ifc.mem_fwd_addr = 5'd3; ifc.mem_fwd_data = 32'h10;
        smp();
        retire("subu_raw");
        chk("raw_allowin", 32'(ifc.id_allowin), 32'd1);
        // MEM beats WB, r0 never forwarded
        cyc();
        clr();
        issue(32'h108, ADDU, 5'd5, 5'd0, 32'h1, 32'h99, 0, 0, 0, 0, 1, 5'd6);
        push(32'h108, 32'hAAAA, 32'h0, ADDU, 1, 5'd6);
        cyc();
        ifc.id_valid = 0;
        ifc.mem_fwd_en = 1; ifc.mem_fwd_addr = 5'd5; ifc.mem_fwd_data = 32'hAAAA;
        ifc.wb_fwd_en = 1; ifc.wb_fwd_addr = 5'd5; ifc.wb_fwd_data = 32'h5555;
        smp();
        retire("prio");
        cyc();
        clr();
        issue(32'h10C, ADDU, 5'd0, 5'd0, 32'h77, 32'h88, 0, 0, 0, 0, 0, 5'd0);
        push(32'h10C, 32'h0, 32'h0, ADDU, 0, 5'd0);
        cyc();
        ifc.id_valid = 0;
        ifc.mem_fwd_en = 1; ifc.mem_fwd_addr = 5'd0; ifc.mem_fwd_data = 32'hFFFF;
        ifc.wb_fwd_en = 1; ifc.wb_fwd_addr = 5'd0; ifc.wb_fwd_data = 32'hEEEE;
        smp();
        retire("r0");
        // load-use stall on rt
        cyc();
        clr();
        issue(32'h110, ADDU, 5'd8, 5'd9, 32'h3, 32'h0, 0, 0, 0, 0, 1, 5'd10);
        push(32'h110, 32'h3, 32'h1234, ADDU, 1, 5'd10);
        cyc();
        issue(32'h114, SUBU, 5'd1, 5'd2, 32'h1, 32'h2, 0, 0, 0, 0, 1, 5'd11);
        push(32'h114, 32'h1, 32'h2, SUBU, 1, 5'd11);
        ifc.mem_fwd_en = 1; ifc.mem_fwd_addr = 5'd9; ifc.mem_fwd_rdy = 0; ifc.mem_fwd_data = 32'hDEAD;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk($sformatf("lu_vld%0d", i), 32'(ifc.ex_to_mem_valid), 32'd0);
            chk($sformatf("lu_allowin%0d", i), 32'(ifc.id_allowin), 32'd0);
            cyc();
        end
        ifc.mem_fwd_rdy = 1; ifc.mem_fwd_data = 32'h1234;
        smp();
        chk("lu_allowin_rel", 32'(ifc.id_allowin), 32'd1);
        retire("loaduse");
        cyc();
        clr();
        smp();
        retire("after_lu");
        // stall refresh from a WB producer that leaves during the stall
        cyc();
        issue(32'h118, ADDU, 5'd1, 5'd7, 32'h1, 32'h0, 0, 0, 0, 0, 1, 5'd13);
        push(32'h118, 32'h1, 32'hBEEF, ADDU, 1, 5'd13);
        cyc();
        ifc.id_valid = 0; ifc.mem_allowin = 0;
        ifc.wb_fwd_en = 1; ifc.wb_fwd_addr = 5'd7; ifc.wb_fwd_data = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk($sformatf("st_db%0d", i), ifc.alu_db, 32'hBEEF);
            chk($sformatf("st_allowin%0d", i), 32'(ifc.id_allowin), 32'd0);
            cyc();
            ifc.wb_fwd_en = 0; ifc.wb_fwd_data = 32'h0;
        end
        ifc.mem_allowin = 1;
        smp();
        retire("stall_rel");
        // flush drops both the held and the incoming instruction
        cyc();
        clr();
        issue(32'h11C, SUBU, 5'd1, 5'd2, 32'h1, 32'h2, 0, 0, 0, 0, 1, 5'd12);
        cyc();
        issue(32'h120, ADDU, 5'd1, 5'd2, 32'h1, 32'h2, 0, 0, 0, 0, 1, 5'd14);
        ifc.flush = 1;
        smp();
        chk("fl_vld_now", 32'(ifc.ex_to_mem_valid), 32'd0);
        cyc();
        clr();
        smp();
        chk("fl_ctl", 32'(ifc.alu_control), 32'd0);
        chk("fl_wen", 32'(ifc.ex_wr_en), 32'd0);
        chk("fl_vld", 32'(ifc.ex_to_mem_valid), 32'd0);
        cyc();
        issue(32'h124, SLL, 5'd0, 5'd2, 32'h0, 32'h1, 0, 5'd4, 1, 0, 1, 5'd15);
        push(32'h124, 32'h4, 32'h1, SLL, 1, 5'd15);
        cyc();
        clr();
        smp();
        retire("sll");
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
